// File: rtl/constants_pkg.sv
// Core-wide sizing constants shared by the RV32I pipeline stages.
package constants_pkg;

    localparam int ARCH_LEN     = 32;
    localparam int NUM_REGS     = 32;
    localparam int REG_ADDR_LEN = 5;

endpackage : constants_pkg

// File: rtl/instruction_pkg.sv
// Instruction encodings, the decoded-instruction record handed to execute,
// and the immediate/operand helpers used by the decode stage.
package instruction_pkg;

    import constants_pkg::*;

    typedef enum logic [6:0] {
        OP_R      = 7'b0110011,
        OP_I_ALU  = 7'b0010011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_BRANCH = 7'b1100011,
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111
    } opcode_e;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_fmt_e;

    // opcode is kept as raw bits so illegal encodings still reach execute intact
    typedef struct packed {
        logic                    valid;
        logic [ARCH_LEN-1:0]     pc;
        logic [6:0]              opcode;
        logic [REG_ADDR_LEN-1:0] rd;
        logic [REG_ADDR_LEN-1:0] rs1;
        logic [REG_ADDR_LEN-1:0] rs2;
        logic [2:0]              func3;
        logic [6:0]              func7;
        logic [ARCH_LEN-1:0]     src_data_1;
        logic [ARCH_LEN-1:0]     src_data_2;
        logic [ARCH_LEN-1:0]     immediate;
        logic                    is_i;
        logic                    we_rd;
        logic                    illegal;
    } inst_decoded_t;

    function automatic logic [ARCH_LEN-1:0] build_imm(input logic [31:0] inst,
                                                      input imm_fmt_e fmt);
        logic [ARCH_LEN-1:0] imm;
        case (fmt)
            IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
            IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U:   imm = {inst[31:12], 12'b0};
            IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

    // x0 beats the bypass so a writeback aimed at x0 can never leak through
    function automatic logic [ARCH_LEN-1:0] read_operand(
        input logic [REG_ADDR_LEN-1:0] rs,
        input logic                    wb_en,
        input logic [REG_ADDR_LEN-1:0] wb_addr,
        input logic [ARCH_LEN-1:0]     wb_data,
        input logic [ARCH_LEN-1:0]     rf_data);
        if (rs == '0)
            return '0;
        else if (wb_en && (wb_addr == rs))
            return wb_data;
        else
            return rf_data;
    endfunction

endpackage : instruction_pkg

// File: rtl/decode_stage_if.sv
// Fetch/writeback-facing bus of the decode stage plus its decoded output.
interface decode_stage_if;

    import constants_pkg::*;
    import instruction_pkg::*;

    logic [31:0]             inst_in;
    logic [ARCH_LEN-1:0]     pc_in;
    logic                    valid_in;
    logic                    stall;
    logic                    flush;
    logic                    wb_en;
    logic [REG_ADDR_LEN-1:0] wb_addr;
    logic [ARCH_LEN-1:0]     wb_data;
    logic                    ready_out;
    inst_decoded_t           inst_dec_out;

    modport master (
        output inst_in, pc_in, valid_in, stall, flush, wb_en, wb_addr, wb_data,
        input  ready_out, inst_dec_out
    );

    modport slave (
        input  inst_in, pc_in, valid_in, stall, flush, wb_en, wb_addr, wb_data,
        output ready_out, inst_dec_out
    );

endinterface : decode_stage_if

// File: rtl/register_file.sv
// Integer register file: two combinational reads, one synchronous write,
// x0 hardwired to zero.
module register_file
    import constants_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [REG_ADDR_LEN-1:0] rs1_addr,
    input  logic [REG_ADDR_LEN-1:0] rs2_addr,
    output logic [ARCH_LEN-1:0]     rs1_data,
    output logic [ARCH_LEN-1:0]     rs2_data,
    input  logic                    we,
    input  logic [REG_ADDR_LEN-1:0] wr_addr,
    input  logic [ARCH_LEN-1:0]     wr_data
);

    logic [ARCH_LEN-1:0] regs [NUM_REGS];

    // NOTE: the array is reset explicitly because architectural state must read
    // zero after reset; this forces flops rather than a RAM macro.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else if (we && (wr_addr != '0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign rs1_data = (rs1_addr == '0) ? '0 : regs[rs1_addr];
    assign rs2_data = (rs2_addr == '0) ? '0 : regs[rs2_addr];

endmodule : register_file

// File: rtl/decode_stage.sv
// RV32I decode stage: field/immediate decode, operand read with writeback
// bypass, and the decode->execute pipeline register with stall/flush.
module decode_stage
    import constants_pkg::*;
    import instruction_pkg::*;
(
    input logic           clk,
    input logic           rst,
    decode_stage_if.slave bus
);

    logic [ARCH_LEN-1:0] rf_rs1_data;
    logic [ARCH_LEN-1:0] rf_rs2_data;
    inst_decoded_t       dec;
    inst_decoded_t       out_q;
    imm_fmt_e            imm_fmt;
    logic                writes_rd;

    register_file u_register_file (
        .clk      (clk),
        .rst      (rst),
        .rs1_addr (bus.inst_in[19:15]),
        .rs2_addr (bus.inst_in[24:20]),
        .rs1_data (rf_rs1_data),
        .rs2_data (rf_rs2_data),
        .we       (bus.wb_en),
        .wr_addr  (bus.wb_addr),
        .wr_data  (bus.wb_data)
    );

    // NOTE: every variable written here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        dec       = '0;
        imm_fmt   = IMM_NONE;
        writes_rd = 1'b0;

        dec.valid  = bus.valid_in;
        dec.pc     = bus.pc_in;
        dec.opcode = bus.inst_in[6:0];
        dec.rd     = bus.inst_in[11:7];
        dec.func3  = bus.inst_in[14:12];
        dec.rs1    = bus.inst_in[19:15];
        dec.rs2    = bus.inst_in[24:20];
        dec.func7  = bus.inst_in[31:25];

        case (bus.inst_in[6:0])
            OP_R:      writes_rd = 1'b1;
            OP_I_ALU:  begin writes_rd = 1'b1; dec.is_i = 1'b1; imm_fmt = IMM_I; end
            OP_LOAD:   begin writes_rd = 1'b1; dec.is_i = 1'b1; imm_fmt = IMM_I; end
            OP_JALR:   begin writes_rd = 1'b1; dec.is_i = 1'b1; imm_fmt = IMM_I; end
            OP_STORE:  imm_fmt = IMM_S;
            OP_BRANCH: imm_fmt = IMM_B;
            OP_LUI:    begin writes_rd = 1'b1; imm_fmt = IMM_U; end
            OP_AUIPC:  begin writes_rd = 1'b1; imm_fmt = IMM_U; end
            OP_JAL:    begin writes_rd = 1'b1; imm_fmt = IMM_J; end
            default:   dec.illegal = 1'b1;
        endcase

        // bubbles must never claim a destination, whatever bits they carry
        dec.we_rd      = writes_rd && (dec.rd != '0) && bus.valid_in;
        dec.immediate  = build_imm(bus.inst_in, imm_fmt);
        dec.src_data_1 = read_operand(dec.rs1, bus.wb_en, bus.wb_addr, bus.wb_data, rf_rs1_data);
        dec.src_data_2 = read_operand(dec.rs2, bus.wb_en, bus.wb_addr, bus.wb_data, rf_rs2_data);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q <= '0;
        end else if (bus.flush) begin
            out_q.valid <= 1'b0;
            out_q.we_rd <= 1'b0;
        end else if (bus.stall) begin
            // keep held operands coherent with writebacks that land during the stall
            if (bus.wb_en && (bus.wb_addr != '0) && (bus.wb_addr == out_q.rs1))
                out_q.src_data_1 <= bus.wb_data;
            if (bus.wb_en && (bus.wb_addr != '0) && (bus.wb_addr == out_q.rs2))
                out_q.src_data_2 <= bus.wb_data;
        end else begin
            out_q <= dec;
        end
    end

    assign bus.ready_out    = !bus.stall;
    assign bus.inst_dec_out = out_q;

endmodule : decode_stage

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed vectors push expected records,
// a monitor pops and compares one record per clock edge.
module tb_decode_stage;

    import constants_pkg::*;
    import instruction_pkg::*;

    localparam int K_FULL   = 1;  // every field of the record
    localparam int K_VALID  = 2;  // valid only (flush)
    localparam int K_BUBBLE = 3;  // valid and we_rd (valid_in low)

    typedef struct {
        int            kind;
        inst_decoded_t exp;
        logic          ready;
    } sb_entry_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    sb_entry_t sb_q[$];
    sb_entry_t cur;

    decode_stage_if bus ();

    decode_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic inst_decoded_t mk(
        input logic [31:0] pc, input logic [6:0] opcode, input logic [4:0] rd,
        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
        input logic [6:0] f7, input logic [31:0] s1, input logic [31:0] s2,
        input logic [31:0] imm, input logic is_i, input logic we, input logic ill);
        inst_decoded_t r;
        r.valid = 1'b1; r.pc = pc; r.opcode = opcode; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2;
        r.func3 = f3; r.func7 = f7; r.src_data_1 = s1; r.src_data_2 = s2; r.immediate = imm;
        r.is_i = is_i; r.we_rd = we; r.illegal = ill;
        return r;
    endfunction

    task automatic drive(input logic [31:0] inst, input logic [31:0] pc, input logic vin,
                         input logic stall, input logic flush, input logic wb_en,
                         input logic [4:0] wb_addr, input logic [31:0] wb_data,
                         input int kind, input inst_decoded_t exp);
        sb_entry_t e;
        @(negedge clk);
        bus.inst_in = inst;  bus.pc_in = pc;     bus.valid_in = vin;
        bus.stall = stall;   bus.flush = flush;
        bus.wb_en = wb_en;   bus.wb_addr = wb_addr; bus.wb_data = wb_data;
        e.kind = kind; e.exp = exp; e.ready = !stall;
        sb_q.push_back(e);
    endtask

    // monitor: one expected record per edge, compared #1 after the edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                cur = sb_q.pop_front();
                check("ready_out", {31'b0, bus.ready_out}, {31'b0, cur.ready});
                check("valid", {31'b0, bus.inst_dec_out.valid}, {31'b0, cur.exp.valid});
                if (cur.kind == K_BUBBLE)
                    check("bubble_we_rd", {31'b0, bus.inst_dec_out.we_rd}, 32'd0);
                if (cur.kind == K_FULL) begin
                    check("pc",         bus.inst_dec_out.pc,         cur.exp.pc);
                    check("opcode",     {25'b0, bus.inst_dec_out.opcode}, {25'b0, cur.exp.opcode});
                    check("rd",         {27'b0, bus.inst_dec_out.rd},     {27'b0, cur.exp.rd});
                    check("rs1",        {27'b0, bus.inst_dec_out.rs1},    {27'b0, cur.exp.rs1});
                    check("rs2",        {27'b0, bus.inst_dec_out.rs2},    {27'b0, cur.exp.rs2});
                    check("func3",      {29'b0, bus.inst_dec_out.func3},  {29'b0, cur.exp.func3});
                    check("func7",      {25'b0, bus.inst_dec_out.func7},  {25'b0, cur.exp.func7});
                    check("src_data_1", bus.inst_dec_out.src_data_1, cur.exp.src_data_1);
                    check("src_data_2", bus.inst_dec_out.src_data_2, cur.exp.src_data_2);
                    check("immediate",  bus.inst_dec_out.immediate,  cur.exp.immediate);
                    check("is_i",       {31'b0, bus.inst_dec_out.is_i},    {31'b0, cur.exp.is_i});
                    check("we_rd",      {31'b0, bus.inst_dec_out.we_rd},   {31'b0, cur.exp.we_rd});
                    check("illegal",    {31'b0, bus.inst_dec_out.illegal}, {31'b0, cur.exp.illegal});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        inst_decoded_t e_sub, e_sub_held, e_none;
        e_none     = '0;
        e_sub      = mk(32'h10C, 7'h33, 5'd3, 5'd2, 5'd4, 3'd0, 7'h20, 32'h22, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        e_sub_held = e_sub;
        e_sub_held.src_data_2 = 32'hAA;

        bus.inst_in = '0; bus.pc_in = '0; bus.valid_in = 1'b0; bus.stall = 1'b0;
        bus.flush = 1'b0; bus.wb_en = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;

        #1;
        check("reset_out_zero", {31'b0, bus.inst_dec_out == '0}, 32'd1);
        check("reset_ready",    {31'b0, bus.ready_out}, 32'd1);
        @(negedge clk);
        rst = 1'b1;

        // addi x1, x0, -5
        drive(32'hFFB00093, 32'h100, 1, 0, 0, 0, 5'd0, 32'h0, K_FULL,
              mk(32'h100, 7'h13, 5'd1, 5'd0, 5'd27, 3'd0, 7'h7F, 32'h0, 32'h0, 32'hFFFFFFFB, 1'b1, 1'b1, 1'b0));
        // add x6, x5, x5 with x5 = 0x1234 written the same cycle (bypass)
        drive(32'h00528333, 32'h104, 1, 0, 0, 1, 5'd5, 32'h1234, K_FULL,
              mk(32'h104, 7'h33, 5'd6, 5'd5, 5'd5, 3'd0, 7'h00, 32'h1234, 32'h1234, 32'h0, 1'b0, 1'b1, 1'b0));
        // same add now reads the register file; meanwhile x2 = 0x22
        drive(32'h00528333, 32'h108, 1, 0, 0, 1, 5'd2, 32'h22, K_FULL,
              mk(32'h108, 7'h33, 5'd6, 5'd5, 5'd5, 3'd0, 7'h00, 32'h1234, 32'h1234, 32'h0, 1'b0, 1'b1, 1'b0));
        // sub x3, x2, x4
        drive(32'h404101B3, 32'h10C, 1, 0, 0, 0, 5'd0, 32'h0, K_FULL, e_sub);
        // stall; writeback x4 = 0xAA refreshes held src_data_2
        drive(32'hFFB00093, 32'h110, 1, 1, 0, 1, 5'd4, 32'hAA, K_FULL, e_sub_held);
        // stall; unrelated writeback leaves the held record alone
        drive(32'hFFB00093, 32'h110, 1, 1, 0, 1, 5'd9, 32'h55, K_FULL, e_sub_held);
        // flush and stall together: flush wins
        drive(32'hFFB00093, 32'h110, 1, 1, 1, 0, 5'd0, 32'h0, K_VALID, e_none);
        // sw x2, 8(x1)
        drive(32'h0020A423, 32'h200, 1, 0, 0, 0, 5'd0, 32'h0, K_FULL,
              mk(32'h200, 7'h23, 5'd8, 5'd1, 5'd2, 3'd2, 7'h00, 32'h0, 32'h22, 32'h8, 1'b0, 1'b0, 1'b0));
        // beq x0, x4, -4 (x4 written during the stall)
        drive(32'hFE400EE3, 32'h204, 1, 0, 0, 0, 5'd0, 32'h0, K_FULL,
              mk(32'h204, 7'h63, 5'd29, 5'd0, 5'd4, 3'd0, 7'h7F, 32'h0, 32'hAA, 32'hFFFFFFFC, 1'b0, 1'b0, 1'b0));
        // add x7, x0, x0 with a same-cycle writeback to x0
        drive(32'h000003B3, 32'h208, 1, 0, 0, 1, 5'd0, 32'hFFFFFFFF, K_FULL,
              mk(32'h208, 7'h33, 5'd7, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0));
        drive(32'h000003B3, 32'h20C, 1, 0, 0, 0, 5'd0, 32'h0, K_FULL,
              mk(32'h20C, 7'h33, 5'd7, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0));
        // opcode 0x7F is illegal
        drive(32'h0000037F, 32'h210, 1, 0, 0, 0, 5'd0, 32'h0, K_FULL,
              mk(32'h210, 7'h7F, 5'd6, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1));
        // lui x10, 0x12345
        drive(32'h12345537, 32'h214, 1, 0, 0, 0, 5'd0, 32'h0, K_FULL,
              mk(32'h214, 7'h37, 5'd10, 5'd8, 5'd3, 3'd5, 7'h09, 32'h0, 32'h0, 32'h12345000, 1'b0, 1'b1, 1'b0));
        // bubble carrying an rd-writing encoding must not assert we_rd
        drive(32'h00528333, 32'h218, 0, 0, 0, 0, 5'd0, 32'h0, K_BUBBLE, e_none);
        // sub again with x2/x4 populated, then hold it under stall
        e_sub.pc = 32'h300; e_sub.src_data_2 = 32'hAA;
        drive(32'h404101B3, 32'h300, 1, 0, 0, 0, 5'd0, 32'h0, K_FULL, e_sub);
        drive(32'h00528333, 32'h304, 1, 1, 0, 0, 5'd0, 32'h0, K_FULL, e_sub);

        // asynchronous reset in the middle of the stall
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_out_zero", {31'b0, bus.inst_dec_out == '0}, 32'd1);
        check("async_rst_ready",    {31'b0, bus.ready_out}, 32'd0);
        @(negedge clk);
        bus.stall = 1'b0;
        rst = 1'b1;
        #1;
        check("post_rst_valid", {31'b0, bus.inst_dec_out.valid}, 32'd0);

        // registers were cleared: the same sub now reads zero operands
        e_sub.pc = 32'h304; e_sub.src_data_1 = 32'h0; e_sub.src_data_2 = 32'h0;
        drive(32'h404101B3, 32'h304, 1, 0, 0, 0, 5'd0, 32'h0, K_FULL, e_sub);
        drive(32'h00528333, 32'h308, 1, 0, 0, 0, 5'd0, 32'h0, K_FULL,
              mk(32'h308, 7'h33, 5'd6, 5'd5, 5'd5, 3'd0, 7'h00, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0));

        for (int i = 0; i < 10 && sb_q.size() > 0; i++)
            @(negedge clk);
        if (sb_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_decode_stage
